// File: rtl/membus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core membus.
// Byte writes feed a TX FIFO; STATUS and DIV registers are readable.
module membus_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic        mem_wen,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  output logic        mem_rvalid,
  output logic [63:0] mem_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = 16;
  localparam logic [1:0]  SEL_TXDATA = 2'd0;
  localparam logic [1:0]  SEL_STATUS = 2'd1;
  localparam logic [1:0]  SEL_DIV    = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_n;
  logic [DIV_W-1:0] r_div, w_eff_div;
  state_t           r_state, w_state_n;
  logic [DIV_W-1:0] r_cnt, w_cnt_n, r_ediv, w_ediv_n;
  logic [2:0]       r_bit, w_bit_n;
  logic [7:0]       r_shift, w_shift_n;
  logic             r_tx, w_tx_n, r_busy, w_busy_n;
  logic             r_rvalid;
  logic [63:0]      r_rdata, w_rdata;
  logic [1:0]       w_sel;
  logic             w_push_req, w_full, w_empty, w_accept, w_push, w_pop, w_last;
  logic             w_unused_ok;

  assign w_sel      = mem_addr[4:3];
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_req = mem_valid && mem_wen && (w_sel == SEL_TXDATA) && mem_wmask[0];
  assign mem_ready  = !(w_push_req && w_full);
  assign w_accept   = mem_valid && mem_ready;
  assign w_push     = w_accept && w_push_req;
  assign w_eff_div  = (r_div == '0) ? DIV_W'(1) : r_div;
  assign w_last     = (r_cnt == '0);
  assign w_count_n  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_unused_ok = ^{mem_addr[31:5], mem_addr[2:0], mem_wdata[63:16], mem_wmask[7:2]};

  assign mem_rvalid = r_rvalid;
  assign mem_rdata  = r_rdata;
  assign uart_tx    = r_tx;
  assign tx_busy    = r_busy;

  // Read data mux; writes respond with zero data
  always_comb begin
    w_rdata = '0;
    if (!mem_wen) begin
      case (w_sel)
        SEL_STATUS: begin
          w_rdata[0]           = w_full;
          w_rdata[1]           = w_empty;
          w_rdata[2]           = r_busy;
          w_rdata[8 +: CNT_W]  = r_count;
        end
        SEL_DIV: w_rdata[DIV_W-1:0] = r_div;
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_div    <= DIV_W'(DEFAULT_DIV);
    end else begin
      r_rvalid <= w_accept;
      r_rdata  <= w_accept ? w_rdata : '0;
      if (w_accept && mem_wen && (w_sel == SEL_DIV)) begin
        if (mem_wmask[0]) r_div[7:0]  <= mem_wdata[7:0];
        if (mem_wmask[1]) r_div[15:8] <= mem_wdata[15:8];
      end
    end
  end

  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ediv  <= DIV_W'(1);
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ediv  <= w_ediv_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
    end
  end

  // Transmit FSM; uart_tx is computed for the next state so it lands registered
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ediv_n  = r_ediv;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rd_ptr];
          w_ediv_n  = w_eff_div;
          w_cnt_n   = w_eff_div - DIV_W'(1);
          w_state_n = S_START;
          w_tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (w_last) begin
          w_state_n = S_DATA;
          w_cnt_n   = r_ediv - DIV_W'(1);
          w_bit_n   = '0;
          w_tx_n    = r_shift[0];
        end else begin
          w_cnt_n = r_cnt - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_n = r_ediv - DIV_W'(1);
          if (r_bit == 3'd7) begin
            w_state_n = S_STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = {1'b0, r_shift[7:1]};
            w_tx_n    = r_shift[1];
          end
        end else begin
          w_cnt_n = r_cnt - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (w_last) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = r_mem[r_rd_ptr];
            w_ediv_n  = w_eff_div;
            w_cnt_n   = w_eff_div - DIV_W'(1);
            w_state_n = S_START;
            w_tx_n    = 1'b0;
          end else begin
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt - DIV_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
    w_busy_n = (w_state_n != S_IDLE) || (w_count_n != '0);
  end

endmodule
